// File: rtl/fifo_pkt_writer.sv
// Packet writer into the write side of an async FIFO: passes payload words straight through,
// then appends a length word and an XOR checksum word per packet.
module fifo_pkt_writer #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned MAX_LEN = 255
) (
    input  logic             wr_clk,
    input  logic             wr_rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             in_ready,
    input  logic             fifo_full,
    output logic             fifo_wr_en,
    output logic [WIDTH-1:0] fifo_data,
    output logic             busy,
    output logic [15:0]      pkt_count,
    output logic             oversize_err
);

    localparam int unsigned   LW       = $clog2(MAX_LEN + 1);
    localparam logic [LW-1:0] LEN_LAST = LW'(MAX_LEN - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        TRL_LEN = 2'd2,
        TRL_SUM = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [LW-1:0]    r_len;
    logic [WIDTH-1:0] r_sum;
    logic [15:0]      r_pkt_count;
    logic             r_oversize;

    logic             w_ready;
    logic             w_wr_en;
    logic [WIDTH-1:0] w_data;
    logic             w_accept;
    logic             w_trunc;
    logic             w_trl_done;

    always_comb begin
        w_next     = r_state;
        w_ready    = 1'b0;
        w_wr_en    = 1'b0;
        w_data     = '0;
        w_accept   = 1'b0;
        w_trunc    = 1'b0;
        w_trl_done = 1'b0;
        case (r_state)
            IDLE, PAYLOAD: begin
                w_ready  = !fifo_full;
                w_accept = in_valid && w_ready;
                if (w_accept) begin
                    w_wr_en = 1'b1;
                    w_data  = in_data;
                    if (in_last || (MAX_LEN == 1)) begin
                        w_next = TRL_LEN;
                    end else if ((r_state == PAYLOAD) && (r_len == LEN_LAST)) begin
                        // Truncate: close this packet; following words start a new one
                        w_next  = TRL_LEN;
                        w_trunc = 1'b1;
                    end else begin
                        w_next = PAYLOAD;
                    end
                end
            end
            TRL_LEN: begin
                w_wr_en = !fifo_full;
                if (w_wr_en) begin
                    w_data = WIDTH'(r_len);
                    w_next = TRL_SUM;
                end
            end
            TRL_SUM: begin
                w_wr_en = !fifo_full;
                if (w_wr_en) begin
                    w_data     = r_sum;
                    w_next     = IDLE;
                    w_trl_done = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
        // Outputs must read zero for the whole time reset is held, not just after the next edge
        if (!wr_rst) begin
            w_ready    = 1'b0;
            w_wr_en    = 1'b0;
            w_data     = '0;
            w_accept   = 1'b0;
            w_trunc    = 1'b0;
            w_trl_done = 1'b0;
        end
    end

    always_ff @(posedge wr_clk or negedge wr_rst) begin
        if (!wr_rst) begin
            r_state     <= IDLE;
            r_len       <= '0;
            r_sum       <= '0;
            r_pkt_count <= '0;
            r_oversize  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_trl_done) begin
                r_len       <= '0;
                r_sum       <= '0;
                r_pkt_count <= r_pkt_count + 16'd1;
            end else if (w_accept) begin
                r_len <= r_len + LW'(1);
                r_sum <= r_sum ^ in_data;
            end
            if (w_trunc) begin
                r_oversize <= 1'b1;
            end
        end
    end

    assign in_ready     = w_ready;
    assign fifo_wr_en   = w_wr_en;
    assign fifo_data    = w_data;
    assign busy         = (r_state != IDLE);
    assign pkt_count    = r_pkt_count;
    assign oversize_err = r_oversize;

endmodule

// File: tb/tb_fifo_pkt_writer.sv
// Directed and randomized checks of fifo_pkt_writer: one instance at default MAX_LEN,
// one at MAX_LEN=4 for truncation, both fed from the same upstream signals.
module tb_fifo_pkt_writer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       valid;
    logic [7:0] data;
    logic       last;
    logic       full;

    logic       a_ready, a_wen, a_busy, a_oe;
    logic [7:0] a_fd;
    logic [15:0] a_pc;
    logic       b_ready, b_wen, b_busy, b_oe;
    logic [7:0] b_fd;
    logic [15:0] b_pc;

    fifo_pkt_writer #(.WIDTH(8), .MAX_LEN(255)) u_a (
        .wr_clk(clk), .wr_rst(rst_n), .in_valid(valid), .in_data(data), .in_last(last),
        .in_ready(a_ready), .fifo_full(full), .fifo_wr_en(a_wen), .fifo_data(a_fd),
        .busy(a_busy), .pkt_count(a_pc), .oversize_err(a_oe)
    );

    fifo_pkt_writer #(.WIDTH(8), .MAX_LEN(4)) u_b (
        .wr_clk(clk), .wr_rst(rst_n), .in_valid(valid), .in_data(data), .in_last(last),
        .in_ready(b_ready), .fifo_full(full), .fifo_wr_en(b_wen), .fifo_data(b_fd),
        .busy(b_busy), .pkt_count(b_pc), .oversize_err(b_oe)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // FIFO-side capture, sampled mid-cycle
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    int         qa_cyc[$];
    int         busy_cnt = 0;
    int         nrdy_cnt = 0;

    always @(negedge clk) begin
        if (a_wen) begin
            qa.push_back(a_fd);
            qa_cyc.push_back(cyc);
        end
        if (b_wen) qb.push_back(b_fd);
        if (a_busy) busy_cnt <= busy_cnt + 1;
        if (!a_ready) nrdy_cnt <= nrdy_cnt + 1;
    end

    logic [7:0] stim[$];
    logic [7:0] expq[$];

    task automatic send(input int sel, input logic lastflag);
        for (int i = 0; i < stim.size(); i++) begin
            logic acc;
            int   guard;
            valid = 1'b1;
            data  = stim[i];
            last  = lastflag && (i == stim.size() - 1);
            acc   = 1'b0;
            guard = 0;
            while (!acc && guard < 50) begin
                @(negedge clk);
                acc = (sel == 0) ? a_ready : b_ready;
                @(posedge clk); #1;
                guard++;
            end
            check_eq("send_accept", acc, 1);
        end
        valid = 1'b0;
        last  = 1'b0;
        data  = '0;
    endtask

    task automatic wait_idle(input int sel);
        logic bz;
        bz = 1'b1;
        for (int k = 0; k < 50 && bz; k++) begin
            @(negedge clk);
            bz = (sel == 0) ? a_busy : b_busy;
            if (bz) begin
                @(posedge clk); #1;
            end
        end
        check_eq("idle_reached", bz, 0);
        @(posedge clk); #1;
    endtask

    task automatic check_stream(input string tag, input int sel, input int base);
        int n;
        n = ((sel == 0) ? qa.size() : qb.size()) - base;
        check_eq({tag, "_count"}, n, expq.size());
        for (int i = 0; i < expq.size() && i < n; i++) begin
            check_eq(tag, (sel == 0) ? qa[base + i] : qb[base + i], expq[i]);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        valid = 1'b0;
        last  = 1'b0;
        full  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int base, b0, r0;
        logic [7:0] tr_q[$];
        int   mlen, pkt_exp, rem;
        logic [7:0] msum, wd;
        logic have, wl, exp_rdy, exp_wen, acc;
        logic [7:0] exp_d;

        // Reset state, with upstream presenting a word to prove gating
        rst_n = 1'b0; valid = 1'b1; data = 8'hAA; last = 1'b1; full = 1'b0;
        #12;
        check_eq("rst_in_ready", a_ready, 0);
        check_eq("rst_wr_en", a_wen, 0);
        check_eq("rst_fifo_data", a_fd, 0);
        check_eq("rst_busy", a_busy, 0);
        check_eq("rst_pkt_count", a_pc, 0);
        check_eq("rst_oversize", a_oe, 0);
        @(negedge clk);
        rst_n = 1'b1; valid = 1'b0; last = 1'b0;
        @(posedge clk); #1;

        // 3-word packet
        base = qa.size(); b0 = busy_cnt;
        stim = '{8'h11, 8'h22, 8'h33};
        send(0, 1'b1);
        wait_idle(0);
        expq = '{8'h11, 8'h22, 8'h33, 8'h03, 8'h00};
        check_stream("pkt3_word", 0, base);
        check_eq("pkt3_consecutive", qa_cyc[base + 4] - qa_cyc[base], 4);
        check_eq("pkt3_busy_cycles", busy_cnt - b0, 4);
        check_eq("pkt3_pkt_count", a_pc, 1);

        // Single-word packet
        base = qa.size(); r0 = nrdy_cnt;
        stim = '{8'hA5};
        send(0, 1'b1);
        wait_idle(0);
        expq = '{8'hA5, 8'h01, 8'hA5};
        check_stream("pkt1_word", 0, base);
        check_eq("pkt1_not_ready_cycles", nrdy_cnt - r0, 2);
        check_eq("pkt1_pkt_count", a_pc, 2);

        // Backpressure during the length trailer
        base = qa.size();
        stim = '{8'h5A};
        send(0, 1'b1);
        full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("full_wr_en", a_wen, 0);
            check_eq("full_in_ready", a_ready, 0);
            @(posedge clk); #1;
        end
        full = 1'b0;
        @(negedge clk);
        check_eq("unfull_wr_en", a_wen, 1);
        check_eq("unfull_len_word", a_fd, 8'h01);
        @(posedge clk); #1;
        wait_idle(0);
        expq = '{8'h5A, 8'h01, 8'h5A};
        check_stream("bp_word", 0, base);
        check_eq("bp_pkt_count", a_pc, 3);

        // Reset mid-packet
        stim = '{8'h10, 8'h20};
        send(0, 1'b0);
        rst_n = 1'b0; valid = 1'b1; data = 8'h30; full = 1'b0;
        #2;
        check_eq("midrst_in_ready", a_ready, 0);
        check_eq("midrst_wr_en", a_wen, 0);
        check_eq("midrst_fifo_data", a_fd, 0);
        check_eq("midrst_busy", a_busy, 0);
        check_eq("midrst_pkt_count", a_pc, 0);
        @(negedge clk);
        rst_n = 1'b1; valid = 1'b0;
        @(posedge clk); #1;
        base = qa.size();
        stim = '{8'h7F};
        send(0, 1'b1);
        wait_idle(0);
        expq = '{8'h7F, 8'h01, 8'h7F};
        check_stream("postrst_word", 0, base);
        check_eq("postrst_pkt_count", a_pc, 1);
        check_eq("postrst_oversize", a_oe, 0);

        // Randomized traffic against a reference packet model
        do_reset();
        tr_q.delete();
        mlen = 0; msum = '0; pkt_exp = 0; rem = 0; have = 1'b0; wd = '0; wl = 1'b0;
        for (int c = 0; c < 10200; c++) begin
            if (c < 10000) begin
                if (!have) begin
                    if (rem == 0) rem = $urandom_range(1, 8);
                    wd   = 8'($urandom);
                    wl   = (rem == 1);
                    have = 1'b1;
                end
                valid = ($urandom_range(0, 3) != 0);
                data  = valid ? wd : 8'($urandom);
                last  = valid ? wl : 1'($urandom_range(0, 1));
                full  = ($urandom_range(0, 3) == 0);
            end else begin
                valid = 1'b0; last = 1'b0; full = 1'b0;
            end
            @(negedge clk);
            exp_rdy = (tr_q.size() == 0) && !full;
            acc     = valid && exp_rdy;
            if (tr_q.size() > 0) begin
                exp_wen = !full;
                exp_d   = exp_wen ? tr_q[0] : 8'h00;
            end else begin
                exp_wen = acc;
                exp_d   = acc ? data : 8'h00;
            end
            check_eq("rnd_wr_while_full", a_wen & full, 0);
            if (n_fail < 20) begin
                check_eq("rnd_in_ready", a_ready, exp_rdy);
                check_eq("rnd_wr_en", a_wen, exp_wen);
                check_eq("rnd_fifo_data", a_fd, exp_d);
            end
            if (tr_q.size() > 0 && exp_wen) begin
                void'(tr_q.pop_front());
                if (tr_q.size() == 0) pkt_exp++;
            end
            if (acc) begin
                mlen++;
                msum = msum ^ data;
                if (last || mlen == 255) begin
                    tr_q.push_back(8'(mlen));
                    tr_q.push_back(msum);
                    mlen = 0;
                    msum = '0;
                end
                have = 1'b0;
                rem--;
            end
            @(posedge clk); #1;
        end
        check_eq("rnd_trailers_drained", tr_q.size(), 0);
        check_eq("rnd_pkt_count", a_pc, pkt_exp);
        check_eq("rnd_oversize", a_oe, 0);

        // Truncation at MAX_LEN=4
        do_reset();
        base = qb.size();
        stim = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        send(1, 1'b1);
        wait_idle(1);
        expq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h04, 8'h04, 8'h05, 8'h06, 8'h02, 8'h03};
        check_stream("trunc_word", 1, base);
        check_eq("trunc_oversize", b_oe, 1);
        check_eq("trunc_pkt_count", b_pc, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_pkt_writer.md
FIFO_PKT_WRITER -- requirements
Module: fifo_pkt_writer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits (legal range 4..32).
REQ-002 SHALL have parameter MAX_LEN, default 255, maximum payload words per packet (legal range 1..2^WIDTH-1).
REQ-003 SHALL have port wr_clk  input  1  write-domain clock; all state updates on its rising edge.
REQ-004 SHALL have port wr_rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  upstream payload word valid.
REQ-006 SHALL have port in_data  input  WIDTH  upstream payload word.
REQ-007 SHALL have port in_last  input  1  marks the final payload word of a packet; qualified by in_valid.
REQ-008 SHALL have port in_ready  output  1  the block accepts the current upstream word this cycle.
REQ-009 SHALL have port fifo_full  input  1  full flag from the write side of the async FIFO.
REQ-010 SHALL have port fifo_wr_en  output  1  write strobe to the async FIFO.
REQ-011 SHALL have port fifo_data  output  WIDTH  word written to the async FIFO.
REQ-012 SHALL have port busy  output  1  a packet is in progress (state not IDLE).
REQ-013 SHALL have port pkt_count  output  16  number of complete packets written, including trailers.
REQ-014 SHALL have port oversize_err  output  1  sticky flag; a packet was truncated at MAX_LEN.

Function
REQ-015 SHALL implement FSM states IDLE, PAYLOAD, TRL_LEN, TRL_SUM; it SHALL hold a length counter len (width clog2(MAX_LEN+1)) and an XOR checksum sum (WIDTH bits).
REQ-016 SHALL drive in_ready = (state is IDLE or PAYLOAD) and !fifo_full, combinationally.
REQ-017 SHALL accept a beat on a cycle with in_valid and in_ready; that same cycle fifo_wr_en=1 and fifo_data=in_data (zero-latency pass-through, no internal storage of payload).
REQ-018 On each accepted beat, SHALL update len <= len+1 and sum <= sum XOR in_data.
REQ-019 From IDLE, an accepted beat SHALL move to PAYLOAD, or to TRL_LEN if in_last=1 or MAX_LEN=1.
REQ-020 In PAYLOAD, an accepted beat with in_last=1 SHALL move to TRL_LEN; an accepted beat that brings len to MAX_LEN with in_last=0 SHALL also move to TRL_LEN and set oversize_err.
REQ-021 After a truncation, the remaining upstream words SHALL be treated as a new packet; in_last is not remembered.
REQ-022 In TRL_LEN, SHALL drive fifo_wr_en = !fifo_full and fifo_data = len zero-extended to WIDTH; on a write SHALL move to TRL_SUM.
REQ-023 In TRL_SUM, SHALL drive fifo_wr_en = !fifo_full and fifo_data = sum; on a write SHALL move to IDLE, clear len and sum, and increment pkt_count.
REQ-024 pkt_count SHALL wrap from 16'hFFFF to 0.
REQ-025 SHALL never assert fifo_wr_en while fifo_full=1, in any state.
REQ-026 When fifo_wr_en=0, fifo_data SHALL be 0.
REQ-027 in_ready SHALL be 0 in TRL_LEN and TRL_SUM regardless of fifo_full; a held in_valid SHALL stall without loss.
REQ-028 busy SHALL be 1 in PAYLOAD, TRL_LEN, and TRL_SUM, and 0 in IDLE.
REQ-029 A packet on the FIFO SHALL always be N payload words, then one length word (N), then one checksum word, where 1 <= N <= MAX_LEN.

Reset
REQ-030 On wr_rst low, SHALL immediately set state IDLE, len 0, sum 0, pkt_count 0, and oversize_err 0; in_ready, fifo_wr_en, fifo_data, and busy SHALL read 0 while reset is asserted.
REQ-031 Reset mid-packet SHALL abandon the packet; words already written stay in the FIFO, so system reset SHALL also reset both FIFO domains.
REQ-032 After reset deassertion, the first accepted beat SHALL start a new packet at len=0.

Verification
REQ-033 3-word packet 0x11,0x22,0x33 (last on 0x33), fifo_full=0 -> FIFO receives 0x11,0x22,0x33,0x03,0x00 on 5 consecutive cycles; pkt_count=1; busy high for 4 cycles.
REQ-034 Single-word packet 0xA5 with in_last=1 -> FIFO receives 0xA5,0x01,0xA5; in_ready=0 for exactly the 2 trailer cycles.
REQ-035 fifo_full=1 for 3 cycles during TRL_LEN -> fifo_wr_en stays 0 for those 3 cycles; length word written on the first cycle fifo_full=0; no word duplicated or lost.
REQ-036 MAX_LEN=4, 6 words 0x01..0x06 with last on 0x06 -> 0x01..0x04,0x04,0x04 then 0x05,0x06,0x02,0x03; oversize_err=1; pkt_count=2.
REQ-037 wr_rst pulsed low after 2 payload words -> outputs 0 immediately; next packet 0x7F (last) yields 0x7F,0x01,0x7F with pkt_count=1.
REQ-038 Random in_valid and fifo_full over 10k cycles -> a scoreboard reconstructs every packet and the trailers match, and fifo_wr_en && fifo_full is never true.
